// File: rtl/uart_link_defs.sv
// Shared UART link definitions: word tags and byte-pair assembler state encodings.
// Used by uart_byte_pair_asm, uart_demux and the transmit-side muxer.
package uart_link_defs;

    localparam logic [3:0] TAG_PL2_POSX = 4'h1;
    localparam logic [3:0] TAG_PL2_POSY = 4'h2;
    localparam logic [3:0] TAG_SYNC     = 4'hF;

    typedef enum logic {
        S_HIGH = 1'b0,
        S_LOW  = 1'b1
    } pair_state_t;

endpackage : uart_link_defs

// File: rtl/uart_byte_pair_asm.sv
// Packs pairs of received UART bytes into 16-bit words (high byte first), with an
// inter-byte timeout that re-aligns pairing. Optional macro: UART_PAIR_SYNC_FILTER_EN.
module uart_byte_pair_asm
    import uart_link_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [15:0] data,
    output logic        conv8to16valid,
`ifdef UART_PAIR_SYNC_FILTER_EN
    output logic        sync_seen,
`endif
    output logic        frame_drop
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    pair_state_t      r_state;
    logic [7:0]       r_hi_byte;
    logic [CNT_W-1:0] r_timer;
    logic [15:0]      r_data;
    logic             r_valid;
    logic             r_drop;
    logic [15:0]      w_word;

    assign w_word = {r_hi_byte, rx_data};

`ifdef UART_PAIR_SYNC_FILTER_EN
    logic r_sync;
    logic w_is_sync;

    assign w_is_sync = (r_hi_byte[7:4] == TAG_SYNC);
    assign sync_seen = r_sync;
`endif

    // NOTE: every state register uses <= so all of them update from the same
    // pre-edge values; a blocking assignment here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_HIGH;
            r_hi_byte <= 8'h00;
            r_timer   <= '0;
            r_data    <= 16'h0000;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
`ifdef UART_PAIR_SYNC_FILTER_EN
            r_sync    <= 1'b0;
`endif
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
`ifdef UART_PAIR_SYNC_FILTER_EN
            r_sync  <= 1'b0;
`endif
            case (r_state)
                S_HIGH: begin
                    r_timer <= '0;
                    if (rx_done) begin
                        r_hi_byte <= rx_data;
                        r_state   <= S_LOW;
                    end
                end
                S_LOW: begin
                    // A low byte arriving on the last timer cycle still completes the word.
                    if (rx_done) begin
                        r_state <= S_HIGH;
                        r_timer <= '0;
`ifdef UART_PAIR_SYNC_FILTER_EN
                        if (w_is_sync) begin
                            r_sync <= 1'b1;
                        end else begin
                            r_data  <= w_word;
                            r_valid <= 1'b1;
                        end
`else
                        r_data  <= w_word;
                        r_valid <= 1'b1;
`endif
                    end else if (r_timer == TIMER_LAST) begin
                        r_drop  <= 1'b1;
                        r_state <= S_HIGH;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_HIGH;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign data           = r_data;
    assign conv8to16valid = r_valid;
    assign frame_drop     = r_drop;

endmodule : uart_byte_pair_asm

// File: tb/tb_uart_byte_pair_asm.sv
// Self-checking bench for uart_byte_pair_asm: scoreboard of expected words plus
// per-scenario inline checks. Honours UART_PAIR_SYNC_FILTER_EN when defined.
module tb_uart_byte_pair_asm;

    localparam int TO    = 20000;
    localparam int CNT_W = 15;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [15:0] data;
    logic        conv8to16valid;
    logic        frame_drop;
`ifdef UART_PAIR_SYNC_FILTER_EN
    logic        sync_seen;
`endif

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_drop  = 0;
    logic prev_valid = 1'b0;
    logic prev_drop  = 1'b0;
    logic [15:0] exp_q[$];

    uart_byte_pair_asm #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .data           (data),
        .conv8to16valid (conv8to16valid),
`ifdef UART_PAIR_SYNC_FILTER_EN
        .sync_seen      (sync_seen),
`endif
        .frame_drop     (frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (conv8to16valid === 1'b1) begin
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_word: got data=%h, expected no word", data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    bad++;
                    $display("FAIL sb_word: got data=%h, expected %h", data, e);
                end
            end
        end
        if (frame_drop === 1'b1) n_drop++;
        if (conv8to16valid === 1'b1 && frame_drop === 1'b1) begin
            total++;
            bad++;
            $display("FAIL valid_and_drop: got both high, expected at most one");
        end
        if ((conv8to16valid === 1'b1 && prev_valid) || (frame_drop === 1'b1 && prev_drop)) begin
            total++;
            bad++;
            $display("FAIL pulse_width: got strobe high 2 cycles, expected 1");
        end
        prev_valid = (conv8to16valid === 1'b1);
        prev_drop  = (frame_drop === 1'b1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        tick(3);
        total++;
        if (data !== 16'h0000 || conv8to16valid !== 1'b0 || frame_drop !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b d=%b, expected 0000 0 0",
                     data, conv8to16valid, frame_drop);
        end
        #2 rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_timeout;
        int d0;
        d0 = n_drop;
        send_byte(8'h1A);
        tick(TO - 1);
        total++;
        if (frame_drop !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got frame_drop=%b one cycle before timeout, expected 0", frame_drop);
        end
        tick();
        total++;
        if (frame_drop !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse: got frame_drop=%b, expected 1", frame_drop);
        end
        tick();
        total++;
        if (frame_drop !== 1'b0 || n_drop - d0 != 1) begin
            bad++;
            $display("FAIL timeout_once: got frame_drop=%b count=%0d, expected 0 and 1", frame_drop, n_drop - d0);
        end
        total++;
        if (data !== 16'h0000) begin
            bad++;
            $display("FAIL timeout_data_hold: got data=%h, expected 0000", data);
        end
        exp_q.push_back(16'h2005);
        send_byte(8'h20);
        tick(3);
        send_byte(8'h05);
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'h2005) begin
            bad++;
            $display("FAIL realign_word: got v=%b data=%h, expected 1 2005", conv8to16valid, data);
        end
        tick(2);
    endtask

    task automatic test_normal_pair;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        exp_q.push_back(16'h1234);
        send_byte(8'h12);
        tick(999);
        total++;
        if (conv8to16valid !== 1'b0) begin
            bad++;
            $display("FAIL normal_early_valid: got v=%b before low byte, expected 0", conv8to16valid);
        end
        send_byte(8'h34);
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'h1234) begin
            bad++;
            $display("FAIL normal_word: got v=%b data=%h, expected 1 1234", conv8to16valid, data);
        end
        tick();
        total++;
        if (conv8to16valid !== 1'b0 || data !== 16'h1234) begin
            bad++;
            $display("FAIL normal_hold: got v=%b data=%h, expected 0 1234", conv8to16valid, data);
        end
        tick(5);
        total++;
        if (n_valid - v0 != 1 || n_drop != d0) begin
            bad++;
            $display("FAIL normal_counts: got words=%0d drops=%0d, expected 1 0", n_valid - v0, n_drop - d0);
        end
    endtask

    task automatic test_race;
        int d0;
        d0 = n_drop;
        exp_q.push_back(16'h1122);
        send_byte(8'h11);
        tick(TO - 1);
        send_byte(8'h22);
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'h1122 || frame_drop !== 1'b0) begin
            bad++;
            $display("FAIL race_word: got v=%b data=%h d=%b, expected 1 1122 0",
                     conv8to16valid, data, frame_drop);
        end
        tick(TO + 5);
        total++;
        if (n_drop != d0) begin
            bad++;
            $display("FAIL race_no_drop: got drops=%0d, expected 0", n_drop - d0);
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(16'hA1B2);
        exp_q.push_back(16'hC3D4);
        rx_done = 1'b1;
        rx_data = 8'hA1; tick();
        total++;
        if (conv8to16valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_c1: got v=%b, expected 0", conv8to16valid);
        end
        rx_data = 8'hB2; tick();
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'hA1B2) begin
            bad++;
            $display("FAIL b2b_c2: got v=%b data=%h, expected 1 a1b2", conv8to16valid, data);
        end
        rx_data = 8'hC3; tick();
        total++;
        if (conv8to16valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_c3: got v=%b, expected 0", conv8to16valid);
        end
        rx_data = 8'hD4; tick();
        rx_done = 1'b0;
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'hC3D4) begin
            bad++;
            $display("FAIL b2b_c4: got v=%b data=%h, expected 1 c3d4", conv8to16valid, data);
        end
        tick(3);
    endtask

    task automatic test_reset_mid_word;
        exp_q.push_back(16'h2F00);
        send_byte(8'h15);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (data !== 16'h0000 || conv8to16valid !== 1'b0 || frame_drop !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs: got data=%h v=%b d=%b, expected 0000 0 0",
                     data, conv8to16valid, frame_drop);
        end
        tick(2);
        #3 rst_n = 1'b1;
        tick(2);
        send_byte(8'h2F);
        total++;
        if (conv8to16valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_stale_high: got v=%b data=%h, expected 0", conv8to16valid, data);
        end
        send_byte(8'h00);
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'h2F00) begin
            bad++;
            $display("FAIL midreset_word: got v=%b data=%h, expected 1 2f00", conv8to16valid, data);
        end
        tick(3);
    endtask

    task automatic test_sync;
`ifndef UART_PAIR_SYNC_FILTER_EN
        exp_q.push_back(16'hF000);
`endif
        send_byte(8'hF0);
        send_byte(8'h00);
`ifdef UART_PAIR_SYNC_FILTER_EN
        total++;
        if (conv8to16valid !== 1'b0 || sync_seen !== 1'b1 || data !== 16'h2F00) begin
            bad++;
            $display("FAIL sync_filter: got v=%b sync=%b data=%h, expected 0 1 2f00",
                     conv8to16valid, sync_seen, data);
        end
        tick();
        total++;
        if (sync_seen !== 1'b0) begin
            bad++;
            $display("FAIL sync_pulse_width: got sync_seen=%b, expected 0", sync_seen);
        end
`else
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'hF000) begin
            bad++;
            $display("FAIL sync_forward: got v=%b data=%h, expected 1 f000", conv8to16valid, data);
        end
        tick();
`endif
        // A pair following the SYNC word must still align normally.
        exp_q.push_back(16'h1357);
        send_byte(8'h13);
        send_byte(8'h57);
        total++;
        if (conv8to16valid !== 1'b1 || data !== 16'h1357) begin
            bad++;
            $display("FAIL after_sync_word: got v=%b data=%h, expected 1 1357", conv8to16valid, data);
        end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_normal_pair();
        test_race();
        test_back_to_back();
        test_reset_mid_word();
        test_sync();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d words never produced, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_byte_pair_asm
